// File: rtl/writeback_unit.sv
// Purpose : 4-entry register-file writeback queue merging ALU and load results in program order.
// Latency : entry pushed into an empty queue at edge N drives RegWrite/RD/WriteData after edge N+1.
// Backpr. : MemReady while Count<=3; AluReady while Count<=2, or Count==3 with no load offered.
//
// Ports:
//   Clock, Reset_n               sole clock, synchronous active-low reset
//   AluValid/AluRd/AluData       ALU result source, AluReady accepts it
//   MemValid/MemRd/MemData       load result source, MemReady accepts it
//   RD/WriteData/RegWrite        registered register-file write port
//   Pending                      per-register hazard flags (queued or outgoing writes)
//   Count                        queue occupancy 0..4
module writeback_unit (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        AluValid,
  input  logic [1:0]  AluRd,
  input  logic [15:0] AluData,
  output logic        AluReady,
  input  logic        MemValid,
  input  logic [1:0]  MemRd,
  input  logic [15:0] MemData,
  output logic        MemReady,
  output logic [1:0]  RD,
  output logic [15:0] WriteData,
  output logic        RegWrite,
  output logic [3:0]  Pending,
  output logic [2:0]  Count
);

  // Queue storage is deliberately not reset: a slot is only ever read
  // while it lies inside the rd_ptr..rd_ptr+count window.
  logic [1:0]  fifo_rd   [4];
  logic [15:0] fifo_data [4];

  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count_q;

  logic [1:0]  rd_q;
  logic [15:0] write_data_q;
  logic        reg_write_q;

  logic        mem_push;
  logic        alu_push;
  logic        pop;
  logic [1:0]  alu_slot;

  // Readiness looks only at registered occupancy so it never depends on
  // the pop happening in the same cycle.
  assign MemReady = Reset_n & (count_q <= 3'd3);
  assign AluReady = Reset_n & ((count_q <= 3'd2) | ((count_q == 3'd3) & ~MemValid));

  assign mem_push = MemValid & MemReady;
  assign alu_push = AluValid & AluReady;
  assign pop      = (count_q != 3'd0);

  // The load is the older instruction, so on a dual push it takes the
  // first slot and the ALU result lands right behind it.
  assign alu_slot = wr_ptr + 2'(mem_push);

  always_ff @(posedge Clock) begin
    if (mem_push) begin
      fifo_rd[wr_ptr]   <= MemRd;
      fifo_data[wr_ptr] <= MemData;
    end
    if (alu_push) begin
      fifo_rd[alu_slot]   <= AluRd;
      fifo_data[alu_slot] <= AluData;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      wr_ptr       <= 2'd0;
      rd_ptr       <= 2'd0;
      count_q      <= 3'd0;
      rd_q         <= 2'd0;
      write_data_q <= 16'd0;
      reg_write_q  <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + 2'(mem_push) + 2'(alu_push);
      rd_ptr  <= rd_ptr + 2'(pop);
      count_q <= count_q + 3'(mem_push) + 3'(alu_push) - 3'(pop);
      if (pop) begin
        rd_q         <= fifo_rd[rd_ptr];
        write_data_q <= fifo_data[rd_ptr];
        reg_write_q  <= 1'b1;
      end else begin
        reg_write_q  <= 1'b0;
      end
    end
  end

  // A physical slot is live when its distance from the read pointer is
  // below the occupancy; with count 4 every slot is live.
  always_comb begin
    Pending = 4'd0;
    for (int j = 0; j < 4; j++) begin
      if ({1'b0, 2'(j) - rd_ptr} < count_q) begin
        Pending[fifo_rd[j]] = 1'b1;
      end
    end
    if (reg_write_q) begin
      Pending[rd_q] = 1'b1;
    end
  end

  assign RD        = rd_q;
  assign WriteData = write_data_q;
  assign RegWrite  = reg_write_q;
  assign Count     = count_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Purpose : directed self-checking bench for writeback_unit.
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpr. : sources model hold-until-accepted using the expected ready values.
module tb_writeback_unit;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        AluValid;
  logic [1:0]  AluRd;
  logic [15:0] AluData;
  logic        AluReady;
  logic        MemValid;
  logic [1:0]  MemRd;
  logic [15:0] MemData;
  logic        MemReady;
  logic [1:0]  RD;
  logic [15:0] WriteData;
  logic        RegWrite;
  logic [3:0]  Pending;
  logic [2:0]  Count;

  int vectors = 0;
  int errs    = 0;

  always #5 Clock = ~Clock;

  writeback_unit dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .AluValid  (AluValid),
    .AluRd     (AluRd),
    .AluData   (AluData),
    .AluReady  (AluReady),
    .MemValid  (MemValid),
    .MemRd     (MemRd),
    .MemData   (MemData),
    .MemReady  (MemReady),
    .RD        (RD),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .Pending   (Pending),
    .Count     (Count)
  );

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs;
    AluValid = 1'b0; AluRd = 2'd0; AluData = 16'd0;
    MemValid = 1'b0; MemRd = 2'd0; MemData = 16'd0;
  endtask

  task automatic test_reset;
    idle_inputs();
    Reset_n  = 1'b0;
    AluValid = 1'b1;
    MemValid = 1'b1;
    tick();
    tick();
    vectors++; if (Count !== 3'd0)      begin errs++; $display("FAIL rst_count got=%0d exp=0", Count); end
    vectors++; if (RegWrite !== 1'b0)   begin errs++; $display("FAIL rst_regwrite got=%b exp=0", RegWrite); end
    vectors++; if (RD !== 2'd0)         begin errs++; $display("FAIL rst_rd got=%0d exp=0", RD); end
    vectors++; if (WriteData !== 16'd0) begin errs++; $display("FAIL rst_wdata got=%h exp=0000", WriteData); end
    vectors++; if (Pending !== 4'd0)    begin errs++; $display("FAIL rst_pending got=%b exp=0000", Pending); end
    vectors++; if (AluReady !== 1'b0)   begin errs++; $display("FAIL rst_aluready got=%b exp=0", AluReady); end
    vectors++; if (MemReady !== 1'b0)   begin errs++; $display("FAIL rst_memready got=%b exp=0", MemReady); end
    idle_inputs();
    Reset_n = 1'b1;
    #1;
    vectors++; if (AluReady !== 1'b1)   begin errs++; $display("FAIL rel_aluready got=%b exp=1", AluReady); end
    vectors++; if (MemReady !== 1'b1)   begin errs++; $display("FAIL rel_memready got=%b exp=1", MemReady); end
  endtask

  task automatic test_single_write;
    AluValid = 1'b1; AluRd = 2'd2; AluData = 16'h1234;
    tick();
    idle_inputs();
    vectors++; if (Pending !== 4'b0100) begin errs++; $display("FAIL single_pend0 got=%b exp=0100", Pending); end
    vectors++; if (Count !== 3'd1)      begin errs++; $display("FAIL single_count got=%0d exp=1", Count); end
    vectors++; if (RegWrite !== 1'b0)   begin errs++; $display("FAIL single_early got=%b exp=0", RegWrite); end
    tick();
    vectors++; if (RegWrite !== 1'b1)      begin errs++; $display("FAIL single_we got=%b exp=1", RegWrite); end
    vectors++; if (RD !== 2'd2)            begin errs++; $display("FAIL single_rd got=%0d exp=2", RD); end
    vectors++; if (WriteData !== 16'h1234) begin errs++; $display("FAIL single_wdata got=%h exp=1234", WriteData); end
    vectors++; if (Pending !== 4'b0100)    begin errs++; $display("FAIL single_pend1 got=%b exp=0100", Pending); end
    tick();
    vectors++; if (RegWrite !== 1'b0)      begin errs++; $display("FAIL single_we_off got=%b exp=0", RegWrite); end
    vectors++; if (Pending !== 4'b0000)    begin errs++; $display("FAIL single_pend2 got=%b exp=0000", Pending); end
    vectors++; if (WriteData !== 16'h1234) begin errs++; $display("FAIL single_hold got=%h exp=1234", WriteData); end
  endtask

  task automatic test_simultaneous;
    MemValid = 1'b1; MemRd = 2'd1; MemData = 16'hAAAA;
    AluValid = 1'b1; AluRd = 2'd1; AluData = 16'h5555;
    #1;
    vectors++; if (MemReady !== 1'b1) begin errs++; $display("FAIL simul_mr got=%b exp=1", MemReady); end
    vectors++; if (AluReady !== 1'b1) begin errs++; $display("FAIL simul_ar got=%b exp=1", AluReady); end
    tick();
    idle_inputs();
    vectors++; if (Count !== 3'd2)      begin errs++; $display("FAIL simul_count got=%0d exp=2", Count); end
    vectors++; if (Pending !== 4'b0010) begin errs++; $display("FAIL simul_pend0 got=%b exp=0010", Pending); end
    tick();
    vectors++; if (RegWrite !== 1'b1 || WriteData !== 16'hAAAA)
      begin errs++; $display("FAIL simul_first got=%b/%h exp=1/aaaa", RegWrite, WriteData); end
    vectors++; if (Pending !== 4'b0010) begin errs++; $display("FAIL simul_pend1 got=%b exp=0010", Pending); end
    tick();
    vectors++; if (RegWrite !== 1'b1 || WriteData !== 16'h5555 || RD !== 2'd1)
      begin errs++; $display("FAIL simul_second got=%b/%0d/%h exp=1/1/5555", RegWrite, RD, WriteData); end
    vectors++; if (Pending !== 4'b0010) begin errs++; $display("FAIL simul_pend2 got=%b exp=0010", Pending); end
    tick();
    vectors++; if (RegWrite !== 1'b0 || Pending !== 4'b0000)
      begin errs++; $display("FAIL simul_done got=%b/%b exp=0/0000", RegWrite, Pending); end
  endtask

  // Mem offers M0..M2 and ALU holds A0..A5 while the queue drains.
  // Hand trace: counts 2,3,3,3,3,3,3,2,1,0,0; ALU stalled only at cycle 2
  // (Count==3 with a load offered); drain order M0 A0 M1 A1 M2 A2 A3 A4 A5.
  task automatic test_fill_backpressure;
    logic [2:0]  exp_count [11] = '{3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    logic        exp_ar    [7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] exp_out   [9]  = '{16'hA000, 16'hB000, 16'hA001, 16'hB001, 16'hA002,
                                    16'hB002, 16'hB003, 16'hB004, 16'hB005};
    logic [1:0]  exp_rd    [9]  = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    int mi = 0;
    int ai = 0;
    for (int c = 0; c < 11; c++) begin
      MemValid = (mi < 3); MemRd = 2'd1; MemData = 16'(16'hA000 + mi);
      AluValid = (ai < 6); AluRd = 2'd2; AluData = 16'(16'hB000 + ai);
      #1;
      if (c < 7) begin
        vectors++; if (AluReady !== exp_ar[c])
          begin errs++; $display("FAIL fill_ar c=%0d got=%b exp=%b", c, AluReady, exp_ar[c]); end
      end
      if (MemValid) begin
        vectors++; if (MemReady !== 1'b1)
          begin errs++; $display("FAIL fill_mr c=%0d got=%b exp=1", c, MemReady); end
        mi++;
      end
      if (AluValid && exp_ar[c]) ai++;
      tick();
      vectors++; if (Count !== exp_count[c])
        begin errs++; $display("FAIL fill_count c=%0d got=%0d exp=%0d", c, Count, exp_count[c]); end
      if (c >= 1 && c <= 9) begin
        vectors++; if (RegWrite !== 1'b1 || WriteData !== exp_out[c-1] || RD !== exp_rd[c-1])
          begin errs++; $display("FAIL fill_out c=%0d got=%b/%0d/%h exp=1/%0d/%h",
                                 c, RegWrite, RD, WriteData, exp_rd[c-1], exp_out[c-1]); end
      end else begin
        vectors++; if (RegWrite !== 1'b0)
          begin errs++; $display("FAIL fill_idle c=%0d got=%b exp=0", c, RegWrite); end
      end
    end
    idle_inputs();
  endtask

  // Ten back-to-back single pushes keep one entry queued and one outgoing,
  // so both pointers wrap twice.
  task automatic test_pointer_wrap;
    logic [3:0] exp_pend;
    for (int c = 0; c < 12; c++) begin
      AluValid = (c < 10); AluRd = 2'(c); AluData = 16'(16'h3C00 + c);
      #1;
      if (c < 10) begin
        vectors++; if (AluReady !== 1'b1)
          begin errs++; $display("FAIL wrap_ar c=%0d got=%b exp=1", c, AluReady); end
      end
      tick();
      exp_pend = 4'd0;
      if (c < 10) exp_pend[c % 4] = 1'b1;
      if (c >= 1 && c <= 10) exp_pend[(c - 1) % 4] = 1'b1;
      vectors++; if (Pending !== exp_pend)
        begin errs++; $display("FAIL wrap_pend c=%0d got=%b exp=%b", c, Pending, exp_pend); end
      if (c >= 1 && c <= 10) begin
        vectors++; if (RegWrite !== 1'b1 || WriteData !== 16'(16'h3C00 + c - 1) || RD !== 2'(c - 1))
          begin errs++; $display("FAIL wrap_out c=%0d got=%b/%0d/%h exp=1/%0d/%h",
                                 c, RegWrite, RD, WriteData, (c - 1) % 4, 16'(16'h3C00 + c - 1)); end
      end else begin
        vectors++; if (RegWrite !== 1'b0)
          begin errs++; $display("FAIL wrap_idle c=%0d got=%b exp=0", c, RegWrite); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_drain;
    MemValid = 1'b1; MemRd = 2'd0; MemData = 16'h1111;
    AluValid = 1'b1; AluRd = 2'd3; AluData = 16'h2222;
    tick();
    MemData = 16'h3333; AluData = 16'h4444;
    tick();
    idle_inputs();
    vectors++; if (Count !== 3'd3) begin errs++; $display("FAIL mid_setup got=%0d exp=3", Count); end
    Reset_n  = 1'b0;
    MemValid = 1'b1;
    AluValid = 1'b1;
    #1;
    vectors++; if (AluReady !== 1'b0 || MemReady !== 1'b0)
      begin errs++; $display("FAIL mid_rdy_in_rst got=%b/%b exp=0/0", AluReady, MemReady); end
    tick();
    idle_inputs();
    vectors++; if (Count !== 3'd0)      begin errs++; $display("FAIL mid_count got=%0d exp=0", Count); end
    vectors++; if (RegWrite !== 1'b0)   begin errs++; $display("FAIL mid_regwrite got=%b exp=0", RegWrite); end
    vectors++; if (Pending !== 4'd0)    begin errs++; $display("FAIL mid_pending got=%b exp=0000", Pending); end
    vectors++; if (RD !== 2'd0 || WriteData !== 16'd0)
      begin errs++; $display("FAIL mid_outs got=%0d/%h exp=0/0000", RD, WriteData); end
    Reset_n = 1'b1;
    #1;
    vectors++; if (AluReady !== 1'b1 || MemReady !== 1'b1)
      begin errs++; $display("FAIL mid_rdy_after got=%b/%b exp=1/1", AluReady, MemReady); end
    tick();
    vectors++; if (RegWrite !== 1'b0 || Count !== 3'd0)
      begin errs++; $display("FAIL mid_stale got=%b/%0d exp=0/0", RegWrite, Count); end
  endtask

  initial begin
    idle_inputs();
    Reset_n = 1'b0;
    #1;
    test_reset();
    test_single_write();
    test_simultaneous();
    test_fill_backpressure();
    test_pointer_wrap();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have one clock and synchronous active-low reset; all ports as listed:
- Clock  in  1  sole clock; all state updates on rising edge
- Reset_n  in  1  synchronous, active-low reset
- AluValid  in  1  ALU result offered
- AluRd  in  2  ALU destination register
- AluData  in  16  ALU result
- AluReady  out  1  ALU result accepted this edge when AluValid=1
- MemValid  in  1  load result offered
- MemRd  in  2  load destination register
- MemData  in  16  load result
- MemReady  out  1  load result accepted this edge when MemValid=1
- RD  out  2  register-file write address
- WriteData  out  16  register-file write data
- RegWrite  out  1  register-file write enable
- Pending  out  4  bit r=1 while any queued or outgoing write targets register r
- Count  out  3  queued entries, 0..4

Function
REQ-002 SHALL hold a 4-entry FIFO of {Rd[1:0], Data[15:0]}.
- 2-bit read/write pointers, wrapping 3->0.
- Count = occupancy.
REQ-003 MemReady SHALL equal (Count<=3) AND Reset_n.
REQ-004 AluReady SHALL equal Reset_n AND ((Count<=2) OR (Count==3 AND MemValid=0)).
REQ-005 Ready outputs SHALL depend only on the registered Count and MemValid, never on a same-cycle pop.
REQ-006 A transfer SHALL occur on an edge where Valid=1 and Ready=1.
- Valid=1 with Ready=0 is held by the source; nothing is dropped.
REQ-007 On a simultaneous Mem and Alu transfer, Mem SHALL be enqueued first and Alu second, at consecutive FIFO slots.
- Program order is preserved: the load is the older instruction.
REQ-008 On each edge with Count>0 at the start of the cycle, the head entry SHALL be popped into registered outputs RD/WriteData with RegWrite=1.
- On an edge with Count==0, RegWrite SHALL go to 0 and RD/WriteData SHALL hold their values.
REQ-009 Latency:
- An entry pushed into an empty FIFO at edge N SHALL appear with RegWrite=1 in the cycle after edge N+1.
- The register file writes it at edge N+2.
REQ-010 Push and pop on the same edge SHALL update Count by (pushes - pops): one of -1, 0, +1, +2.
REQ-011 Entries SHALL drain strictly FIFO, one per cycle, with no merging or reordering.
- Consecutive writes to the same Rd both appear; the later one wins in the register file.
REQ-012 Pending[r] SHALL be the OR over the valid FIFO entries with Rd==r, plus (RegWrite=1 AND RD==r).
- Combinational from registered state.
REQ-013 Count SHALL never exceed 4.
- Full (Count=4): both Ready=0.
- Empty (Count=0): no pop, RegWrite=0 next cycle.

Reset
REQ-014 While Reset_n=0 at an edge, the block SHALL clear:
- Count to 0 and both pointers to 0
- RegWrite, RD, WriteData and Pending to 0
REQ-015 While Reset_n=0, AluReady and MemReady SHALL be 0.
REQ-016 Reset asserted mid-operation SHALL discard all queued and outgoing entries; no RegWrite=1 in the cycle after the reset edge.
REQ-017 FIFO data storage need not be reset; it SHALL be unobservable while its slot is invalid.

Verification
REQ-018 Single write:
- Stimulus: AluValid=1, AluRd=2, AluData=0x1234 for one edge, FIFO empty.
- Response: Pending=0100 after that edge; next cycle RegWrite=1, RD=2, WriteData=0x1234; then RegWrite=0, Pending=0000.
REQ-019 Simultaneous sources:
- Stimulus: Mem(Rd=1, 0xAAAA) and Alu(Rd=1, 0x5555) on the same edge, Count=0.
- Response: Count=2; outputs are 0xAAAA then 0x5555 on consecutive cycles; Pending[1]=1 until the second write leaves RegWrite.
REQ-020 Fill and backpressure:
- Stimulus: hold AluValid=1 for 6 edges with RegWrite draining.
- Response: Count saturates per REQ-004/010; AluReady=0 whenever Count>=3 with MemValid=1 or Count=4; all 6 values emerge in order.
REQ-021 Count==3 priority:
- Stimulus: Count==3, both Valid=1.
- Response: MemReady=1, AluReady=0; only the Mem entry is accepted.
REQ-022 Pointer wrap:
- Stimulus: push and pop 10 distinct values continuously.
- Response: output order matches input order across pointer wrap 3->0.
REQ-023 Reset mid-drain:
- Stimulus: Count=3, assert Reset_n=0 for one edge.
- Response: next cycle Count=0, RegWrite=0, Pending=0000, Ready outputs 0 during reset and 1 after.
